// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-port arbiter and access sequencer for the shared 16-bit unified memory.
//   Merges the instruction-fetch read port (i_*) and the data read/write port
//   (d_*) onto one memory port. Each granted access holds the memory port for
//   LATENCY cycles, then the grantee sees a one-cycle ack.
//
//   Optional feature macro: ARB_RR_EN
//     defined   -> round-robin arbitration on contention (pointer register)
//     undefined -> fixed priority, data port over fetch port (no pointer)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [15:0]           i_rdata,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [15:0]           d_wdata,
  output logic [15:0]           d_rdata,
  output logic                  d_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  output logic                  busy
);

  // Countdown start value: LATENCY access cycles means cnt runs LATENCY-1..0.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                state_q,     state_d;
  logic [3:0]            cnt_q,       cnt_d;
  // Only the word address is kept; bit 0 is forced to zero on the memory bus.
  logic [ADDR_WIDTH-2:0] addr_q,      addr_d;
  logic                  wr_q,        wr_d;
  logic [15:0]           wdata_q,     wdata_d;
  logic                  gnt_data_q,  gnt_data_d;   // 1 = data port owns the access
  logic [15:0]           i_rdata_q,   i_rdata_d;
  logic [15:0]           d_rdata_q,   d_rdata_d;
  logic                  i_ack_q,     i_ack_d;
  logic                  d_ack_q,     d_ack_d;

  logic                  req_any_s;
  logic                  grant_data_s;

  // Byte-select bits of the request addresses are not needed by a word memory.
  logic                  unused_addr_lsb_s;
  assign unused_addr_lsb_s = i_addr[0] ^ d_addr[0];

`ifdef ARB_RR_EN
  // 1 = fetch port was granted last, so the data port wins the next contention.
  logic                  last_i_q,    last_i_d;
`endif

  assign req_any_s = i_req | d_req;

  // Arbitration: pick the winner among the ports requesting in this IDLE cycle.
  always_comb begin
    grant_data_s = 1'b0;
`ifdef ARB_RR_EN
    if (i_req && d_req) begin
      grant_data_s = last_i_q;
    end else begin
      grant_data_s = d_req;
    end
`else
    grant_data_s = d_req;
`endif
  end

  // Next-state, latched request and response computation for the sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    gnt_data_d = gnt_data_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
`ifdef ARB_RR_EN
    last_i_d   = last_i_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_any_s) begin
          state_d    = ST_ACCESS;
          cnt_d      = CNT_LOAD;
          gnt_data_d = grant_data_s;
`ifdef ARB_RR_EN
          last_i_d   = ~grant_data_s;
`endif
          if (grant_data_s) begin
            addr_d  = d_addr[ADDR_WIDTH-1:1];
            wr_d    = d_wr;
            wdata_d = d_wdata;
          end else begin
            addr_d  = i_addr[ADDR_WIDTH-1:1];
            wr_d    = 1'b0;
            wdata_d = 16'h0000;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Last access cycle: read data is captured on the closing edge and
          // the ack is raised for the RESP cycle that follows.
          state_d = ST_RESP;
          if (gnt_data_q) begin
            d_ack_d = 1'b1;
            if (!wr_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Sequencer state, latched request and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= {(ADDR_WIDTH-1){1'b0}};
      wr_q       <= 1'b0;
      wdata_q    <= 16'h0000;
      gnt_data_q <= 1'b0;
      i_rdata_q  <= 16'h0000;
      d_rdata_q  <= 16'h0000;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      gnt_data_q <= gnt_data_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_ack_q    <= i_ack_d;
      d_ack_q    <= d_ack_d;
    end
  end

`ifdef ARB_RR_EN
  // Round-robin pointer; reset to "fetch last" so the first contention goes to D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_i_q <= 1'b1;
    end else begin
      last_i_q <= last_i_d;
    end
  end
`endif

  // Memory port decode: active only in ACCESS, write strobe on the final cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = {ADDR_WIDTH{1'b0}};
    mem_wdata = 16'h0000;
    if (state_q == ST_ACCESS) begin
      mem_en    = 1'b1;
      mem_wr    = wr_q && (cnt_q == 4'd0);
      mem_addr  = {addr_q, 1'b0};
      mem_wdata = wdata_q;
    end else begin
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = {ADDR_WIDTH{1'b0}};
      mem_wdata = 16'h0000;
    end
  end

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with LATENCY = 3 and a small word memory
//   model. Expected values are hand-derived from the access timing:
//   sample edge E0 -> ACCESS for 3 cycles -> RESP (ack) -> IDLE.
//   Builds with or without ARB_RR_EN; contention expectations follow the macro.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW  = 16;
  localparam int LAT = 3;
`ifdef ARB_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [15:0]   i_rdata;
  logic          i_ack;
  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [15:0]   d_wdata;
  logic [15:0]   d_rdata;
  logic          d_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_en;
  logic          mem_wr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Word-addressed memory model: combinational read, write on the clock edge.
  logic [15:0] mem [0:255];
  logic        mem_loaded = 1'b0;

  assign mem_rdata = mem[mem_addr[8:1]];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8]     <= 16'hA5A5;
      mem[9]     <= 16'hBEEF;
      mem_loaded <= 1'b1;
    end else if (mem_en && mem_wr) begin
      mem[mem_addr[8:1]] <= mem_wdata;
    end
  end

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_addr  (mem_addr),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_en"},    {31'd0, mem_en},    32'd0);
    chk({tag, ".mem_wr"},    {31'd0, mem_wr},    32'd0);
    chk({tag, ".mem_addr"},  {16'd0, mem_addr},  32'd0);
    chk({tag, ".mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
    chk({tag, ".busy"},      {31'd0, busy},      32'd0);
    chk({tag, ".i_ack"},     {31'd0, i_ack},     32'd0);
    chk({tag, ".d_ack"},     {31'd0, d_ack},     32'd0);
    chk({tag, ".i_rdata"},   {16'd0, i_rdata},   32'd0);
    chk({tag, ".d_rdata"},   {16'd0, d_rdata},   32'd0);
  endtask

  initial begin
    logic exp_d;
    int   slot;

    rst_n   = 1'b0;
    i_req   = 1'b0;
    i_addr  = 16'h0000;
    d_req   = 1'b0;
    d_wr    = 1'b0;
    d_addr  = 16'h0000;
    d_wdata = 16'h0000;

    // ---- Reset state ----
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("idle.busy", {31'd0, busy}, 32'd0);

    // ---- Data write 0x1234 to 0x0040 ----
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
    tick();                                        // ACCESS, cnt 2
    chk("wr.c2.mem_en",    {31'd0, mem_en},    32'd1);
    chk("wr.c2.mem_wr",    {31'd0, mem_wr},    32'd0);
    chk("wr.c2.mem_addr",  {16'd0, mem_addr},  32'h0040);
    chk("wr.c2.mem_wdata", {16'd0, mem_wdata}, 32'h1234);
    chk("wr.c2.busy",      {31'd0, busy},      32'd1);
    tick();                                        // ACCESS, cnt 1
    chk("wr.c1.mem_wr",    {31'd0, mem_wr},    32'd0);
    tick();                                        // ACCESS, cnt 0
    chk("wr.c0.mem_en",    {31'd0, mem_en},    32'd1);
    chk("wr.c0.mem_wr",    {31'd0, mem_wr},    32'd1);
    chk("wr.c0.d_ack",     {31'd0, d_ack},     32'd0);
    tick();                                        // RESP
    chk("wr.resp.d_ack",   {31'd0, d_ack},     32'd1);
    chk("wr.resp.i_ack",   {31'd0, i_ack},     32'd0);
    chk("wr.resp.mem_en",  {31'd0, mem_en},    32'd0);
    chk("wr.resp.d_rdata", {16'd0, d_rdata},   32'h0000);
    chk("wr.resp.mem",     {16'd0, mem[8'h20]}, 32'h1234);
    d_req = 1'b0;
    tick();                                        // IDLE
    chk("wr.idle.d_ack",   {31'd0, d_ack},     32'd0);
    chk("wr.idle.busy",    {31'd0, busy},      32'd0);

    // ---- Data read back from odd address 0x0041 ----
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0041; d_wdata = 16'hFFFF;
    tick();
    chk("rd.mem_addr",     {16'd0, mem_addr},  32'h0040);
    chk("rd.mem_wr",       {31'd0, mem_wr},    32'd0);
    tick();
    tick();
    chk("rd.c0.mem_wr",    {31'd0, mem_wr},    32'd0);
    tick();                                        // RESP
    chk("rd.resp.d_ack",   {31'd0, d_ack},     32'd1);
    chk("rd.resp.d_rdata", {16'd0, d_rdata},   32'h1234);
    d_req = 1'b0;
    tick();
    chk("rd.idle.d_ack",   {31'd0, d_ack},     32'd0);

    // ---- Single fetch from 0x0013 (word 9 = 0xBEEF) ----
    i_req = 1'b1; i_addr = 16'h0013;
    tick();
    chk("if.mem_addr",     {16'd0, mem_addr},  32'h0012);
    chk("if.mem_en",       {31'd0, mem_en},    32'd1);
    chk("if.mem_wdata",    {16'd0, mem_wdata}, 32'h0000);
    chk("if.busy",         {31'd0, busy},      32'd1);
    tick();
    tick();
    chk("if.c0.i_ack",     {31'd0, i_ack},     32'd0);
    chk("if.c0.busy",      {31'd0, busy},      32'd1);
    tick();                                        // RESP
    chk("if.resp.i_ack",   {31'd0, i_ack},     32'd1);
    chk("if.resp.d_ack",   {31'd0, d_ack},     32'd0);
    chk("if.resp.i_rdata", {16'd0, i_rdata},   32'hBEEF);
    chk("if.resp.busy",    {31'd0, busy},      32'd1);
    i_req = 1'b0;
    tick();
    chk("if.idle.i_ack",   {31'd0, i_ack},     32'd0);
    chk("if.idle.busy",    {31'd0, busy},      32'd0);
    chk("if.idle.i_rdata", {16'd0, i_rdata},   32'hBEEF);
    chk("if.idle.d_rdata", {16'd0, d_rdata},   32'h1234);

    // ---- Continuous contention, back-to-back: acks every LAT+2 cycles ----
    i_req = 1'b1; i_addr = 16'h0012;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if ((k >= LAT + 1) && (((k - (LAT + 1)) % (LAT + 2)) == 0)) begin
        slot  = (k - (LAT + 1)) / (LAT + 2);
        exp_d = RR_BUILD ? ((slot % 2) == 0) : 1'b1;
        chk($sformatf("cont.k%0d.d_ack", k), {31'd0, d_ack}, {31'd0, exp_d});
        chk($sformatf("cont.k%0d.i_ack", k), {31'd0, i_ack}, {31'd0, ~exp_d});
      end else begin
        chk($sformatf("cont.k%0d.acks", k), {30'd0, i_ack, d_ack}, 32'd0);
      end
    end
    chk("cont.d_rdata", {16'd0, d_rdata}, 32'h1234);
    chk("cont.i_rdata", {16'd0, i_rdata}, RR_BUILD ? 32'hBEEF : 32'hBEEF);
    i_req = 1'b0; d_req = 1'b0;
    tick();
    chk("cont.idle.busy", {31'd0, busy}, 32'd0);

    // ---- Simultaneous request, D wins; changes during ACCESS ignored ----
    i_req = 1'b1; i_addr = 16'h0012;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
    tick();
    chk("sim.d.mem_addr", {16'd0, mem_addr}, 32'h0040);
    d_req = 1'b0; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'h7777;
    tick();
    chk("sim.d.hold_addr", {16'd0, mem_addr}, 32'h0040);
    chk("sim.d.hold_wr",   {31'd0, mem_wr},   32'd0);
    tick();
    tick();                                        // RESP for D
    chk("sim.d.ack",   {30'd0, i_ack, d_ack}, 32'd1);
    tick();                                        // IDLE
    chk("sim.gap.busy", {31'd0, busy}, 32'd0);
    tick();                                        // ACCESS for I
    chk("sim.i.mem_addr", {16'd0, mem_addr}, 32'h0012);
    tick();
    tick();
    tick();                                        // RESP for I
    chk("sim.i.ack",   {30'd0, i_ack, d_ack}, 32'd2);
    i_req = 1'b0;
    tick();
    chk("sim.idle.busy", {31'd0, busy}, 32'd0);
    chk("sim.mem100",    {16'd0, mem[8'h80]}, 32'h0000);

    // ---- Asynchronous reset mid-write to 0x0010 ----
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0010; d_wdata = 16'h5555;
    tick();                                        // cnt 2
    tick();                                        // cnt 1
    chk("rst.pre.mem_en", {31'd0, mem_en}, 32'd1);
    chk("rst.pre.mem_wr", {31'd0, mem_wr}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst.async");
    d_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst.k%0d.acks", k), {30'd0, i_ack, d_ack}, 32'd0);
    end
    chk("rst.mem8", {16'd0, mem[8]}, 32'hA5A5);
    rst_n = 1'b1;
    tick();
    chk("rst.after.busy", {31'd0, busy}, 32'd0);
    chk("rst.after.mem8", {16'd0, mem[8]}, 32'hA5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
